// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad lock sequencer.
//   lock_state_t : sequencer states
//   KEY_W        : width of a keypad digit
//   CNT_W/FAIL_W : widths of the digit and failure counters
//   DEF_*        : default entry length limits
package lock_pkg;

    localparam int unsigned KEY_W       = 2;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned FAIL_W      = 2;
    localparam int unsigned DEF_MAX_LEN = 8;
    localparam int unsigned DEF_MIN_LEN = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        WAIT_RES = 3'd2,
        UNLOCKED = 3'd3,
        LOCKOUT  = 3'd4
    } lock_state_t;

endpackage

// File: rtl/lock_controller_if.sv
// Keypad-event and code-checker signals seen by the lock sequencer.
//   key_valid/key_bits/key_enter/key_clear : single-cycle keypad events
//   chk_match/chk_done                     : checker verdict
//   chk_input/chk_bits/chk_compare/chk_clear : single-cycle checker commands
// master: keypad front-end + checker side; slave: the sequencer.
interface lock_controller_if;
    import lock_pkg::*;

    logic             key_valid;
    logic [KEY_W-1:0] key_bits;
    logic             key_enter;
    logic             key_clear;
    logic             chk_match;
    logic             chk_done;
    logic             chk_input;
    logic [KEY_W-1:0] chk_bits;
    logic             chk_compare;
    logic             chk_clear;

    modport master (
        output key_valid, key_bits, key_enter, key_clear, chk_match, chk_done,
        input  chk_input, chk_bits, chk_compare, chk_clear
    );

    modport slave (
        input  key_valid, key_bits, key_enter, key_clear, chk_match, chk_done,
        output chk_input, chk_bits, chk_compare, chk_clear
    );

endinterface

// File: rtl/lock_timer.sv
// Shared up-counter for the sequencer's timed states.
//   clk, resetn : clock, async active-low reset
//   clear       : restart the count at zero on the next edge
//   limit       : terminal value for the current state
//   tc_c        : count has reached limit (combinational)
module lock_timer #(
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         tc_c
);

    logic [W-1:0] count;

    // Saturating count so a long stay in an untimed state cannot wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + W'(1);
        end
    end

    assign tc_c = (count == limit);

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: forwards digits to the code checker, requests the
// comparison, drives unlock and enforces lockout after repeated failures.
//   clk, resetn  : clock, async active-low reset
//   bus          : keypad events in, checker commands out (slave side)
//   unlock       : lock released
//   locked_out   : keypad ignored after too many failures
//   digit_count  : digits in the current attempt
//   fail_count   : consecutive failed attempts
module lock_controller
    import lock_pkg::*;
#(
    parameter int unsigned MAX_LEN        = DEF_MAX_LEN,
    parameter int unsigned MIN_LEN        = DEF_MIN_LEN,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned UNLOCK_CYCLES  = 1000,
    parameter int unsigned LOCKOUT_CYCLES = 5000,
    parameter int unsigned RESULT_TMO     = 64
) (
    input  logic              clk,
    input  logic              resetn,
    lock_controller_if.slave  bus,
    output logic              unlock,
    output logic              locked_out,
    output logic [CNT_W-1:0]  digit_count,
    output logic [FAIL_W-1:0] fail_count
);

    localparam int unsigned TMR_W =
        $clog2((UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES);

    lock_state_t       state, state_next;
    logic [CNT_W-1:0]  digit_count_next;
    logic [FAIL_W-1:0] fail_count_next, fail_inc;
    logic              chk_input_next, chk_compare_next, chk_clear_next;
    logic [KEY_W-1:0]  chk_bits_next;
    logic [TMR_W-1:0]  tmr_limit;
    logic              tmr_clear, tmr_tc;

    // Timer restarts on every state change; its limit follows the current state.
    assign tmr_clear = (state_next != state);

    always_comb begin
        tmr_limit = '1;
        case (state)
            WAIT_RES: tmr_limit = TMR_W'(RESULT_TMO - 1);
            UNLOCKED: tmr_limit = TMR_W'(UNLOCK_CYCLES - 1);
            LOCKOUT:  tmr_limit = TMR_W'(LOCKOUT_CYCLES - 1);
            default:  tmr_limit = '1;
        endcase
    end

    lock_timer #(.W(TMR_W)) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clear  (tmr_clear),
        .limit  (tmr_limit),
        .tc_c   (tmr_tc)
    );

    // Next-state, counter and strobe logic.
    always_comb begin
        state_next       = state;
        digit_count_next = digit_count;
        fail_count_next  = fail_count;
        chk_input_next   = 1'b0;
        chk_bits_next    = '0;
        chk_compare_next = 1'b0;
        chk_clear_next   = 1'b0;
        fail_inc = (fail_count == FAIL_W'(MAX_FAILS)) ? fail_count
                                                       : fail_count + FAIL_W'(1);

        case (state)
            IDLE: begin
                if (bus.key_valid) begin
                    chk_input_next   = 1'b1;
                    chk_bits_next    = bus.key_bits;
                    digit_count_next = CNT_W'(1);
                    state_next       = ENTRY;
                end
            end
            ENTRY: begin
                if (bus.key_clear) begin
                    chk_clear_next   = 1'b1;
                    digit_count_next = '0;
                    state_next       = IDLE;
                end else if (bus.key_enter) begin
                    if (digit_count >= CNT_W'(MIN_LEN)) begin
                        chk_compare_next = 1'b1;
                        state_next       = WAIT_RES;
                    end else begin
                        // Too-short attempt is a failure in its own right.
                        chk_clear_next   = 1'b1;
                        digit_count_next = '0;
                        fail_count_next  = fail_inc;
                        state_next = (fail_inc == FAIL_W'(MAX_FAILS)) ? LOCKOUT : IDLE;
                    end
                end else if (bus.key_valid && (digit_count < CNT_W'(MAX_LEN))) begin
                    chk_input_next   = 1'b1;
                    chk_bits_next    = bus.key_bits;
                    digit_count_next = digit_count + CNT_W'(1);
                end
            end
            WAIT_RES: begin
                // A verdict arriving on the timeout cycle still counts.
                if (bus.chk_done && bus.chk_match) begin
                    fail_count_next = '0;
                    state_next      = UNLOCKED;
                end else if (bus.chk_done || tmr_tc) begin
                    chk_clear_next   = 1'b1;
                    digit_count_next = '0;
                    fail_count_next  = fail_inc;
                    state_next = (fail_inc == FAIL_W'(MAX_FAILS)) ? LOCKOUT : IDLE;
                end
            end
            UNLOCKED: begin
                if (tmr_tc) begin
                    chk_clear_next   = 1'b1;
                    digit_count_next = '0;
                    state_next       = IDLE;
                end
            end
            LOCKOUT: begin
                if (tmr_tc) begin
                    fail_count_next = '0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters and all outputs registered together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            digit_count     <= '0;
            fail_count      <= '0;
            bus.chk_input   <= 1'b0;
            bus.chk_bits    <= '0;
            bus.chk_compare <= 1'b0;
            bus.chk_clear   <= 1'b0;
            unlock          <= 1'b0;
            locked_out      <= 1'b0;
        end else begin
            state           <= state_next;
            digit_count     <= digit_count_next;
            fail_count      <= fail_count_next;
            bus.chk_input   <= chk_input_next;
            bus.chk_bits    <= chk_bits_next;
            bus.chk_compare <= chk_compare_next;
            bus.chk_clear   <= chk_clear_next;
            unlock          <= (state_next == UNLOCKED);
            locked_out      <= (state_next == LOCKOUT);
        end
    end

endmodule
